// File: rtl/sad_datapath.sv
// SAD engine datapath: operand memories A/B, index counter, accumulator and result register.
// Optional build macro SAD_SATURATE_EN clamps the accumulator at its maximum instead of wrapping.
module sad_datapath #(
  parameter int N      = 256,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SUM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic              AB_rd,
  input  logic              sum_clr,
  input  logic              sum_ld,
  input  logic              sad_reg_ld,
  output logic              i_lt_256,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [SUM_W-1:0]  sad,
  output logic              sad_valid
);

  localparam int            IW    = ADDR_W + 1;
  localparam int            DEPTH = 1 << ADDR_W;
  localparam logic [IW-1:0] I_MAX = IW'(N);

  logic [DATA_W-1:0] mem_a [0:DEPTH-1];
  logic [DATA_W-1:0] mem_b [0:DEPTH-1];

  logic [IW-1:0]     i_q, i_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  sad_q, sad_d;
  logic              sad_valid_q, sad_valid_d;

  logic [DATA_W-1:0] rd_a, rd_b, abs_diff;
  logic [SUM_W-1:0]  diff, sum_acc;

  // Memories are deliberately left out of reset so loaded operands survive an abort.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  // Combinational read: the controller reads, accumulates and advances i in one cycle.
  assign rd_a     = mem_a[i_q[ADDR_W-1:0]];
  assign rd_b     = mem_b[i_q[ADDR_W-1:0]];
  assign abs_diff = (rd_a >= rd_b) ? (rd_a - rd_b) : (rd_b - rd_a);
  assign diff     = AB_rd ? SUM_W'(abs_diff) : '0;

`ifdef SAD_SATURATE_EN
  logic [SUM_W:0] sum_ext;
  assign sum_ext = {1'b0, sum_q} + {1'b0, diff};
  assign sum_acc = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
`else
  assign sum_acc = sum_q + diff;
`endif

  always_comb begin
    i_d         = i_q;
    sum_d       = sum_q;
    sad_d       = sad_q;
    sad_valid_d = sad_valid_q;

    if (i_clr)                       i_d = '0;
    else if (i_inc && (i_q < I_MAX)) i_d = i_q + IW'(1);

    if (sum_clr)     sum_d = '0;
    else if (sum_ld) sum_d = sum_acc;

    // sad samples the register, so a concurrent sum_ld is not yet visible here.
    if (sad_reg_ld) begin
      sad_d       = sum_q;
      sad_valid_d = 1'b1;
    end else if (sum_clr) begin
      sad_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q         <= '0;
      sum_q       <= '0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
    end else begin
      i_q         <= i_d;
      sum_q       <= sum_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
    end
  end

  assign i_lt_256  = (i_q < I_MAX);
  assign sad       = sad_q;
  assign sad_valid = sad_valid_q;

endmodule

// File: tb/tb_sad_datapath.sv
// Directed bench for sad_datapath: table of operand patterns plus hand-written corner sequences.
// A second instance with SUM_W=10 exposes wrap vs SAD_SATURATE_EN behaviour.
module tb_sad_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_clr, i_inc, AB_rd, sum_clr, sum_ld, sad_reg_ld;
  logic        wr_en, wr_sel;
  logic [7:0]  wr_addr, wr_data;
  logic        i_lt_256, sad_valid;
  logic [15:0] sad;
  logic        i_lt_256_10, sad_valid_10;
  logic [9:0]  sad_10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sad_datapath #(.N(256), .DATA_W(8), .ADDR_W(8), .SUM_W(16)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_inc(i_inc), .AB_rd(AB_rd),
    .sum_clr(sum_clr), .sum_ld(sum_ld), .sad_reg_ld(sad_reg_ld), .i_lt_256(i_lt_256),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .sad(sad), .sad_valid(sad_valid)
  );

  sad_datapath #(.N(256), .DATA_W(8), .ADDR_W(8), .SUM_W(10)) dut10 (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_inc(i_inc), .AB_rd(AB_rd),
    .sum_clr(sum_clr), .sum_ld(sum_ld), .sad_reg_ld(sad_reg_ld), .i_lt_256(i_lt_256_10),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .sad(sad_10), .sad_valid(sad_valid_10)
  );

  // kind: 0 = constant c, 1 = k, 2 = 255-k
  typedef struct {
    int a_kind; int a_c;
    int b_kind; int b_c;
    int exp16;
    int exp10_wrap;
    int exp10_sat;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_clr = 0; i_inc = 0; AB_rd = 0; sum_clr = 0; sum_ld = 0; sad_reg_ld = 0; wr_en = 0;
  endtask

  function automatic int pat(input int kind, input int c, input int k);
    if (kind == 1) return k;
    if (kind == 2) return 255 - k;
    return c;
  endfunction

  task automatic load(input int sel, input int kind, input int c);
    for (int k = 0; k < 256; k++) begin
      wr_en = 1; wr_sel = sel[0]; wr_addr = 8'(k); wr_data = 8'(pat(kind, c, k));
      step();
    end
    wr_en = 0;
  endtask

  initial begin
    int exp10;
    tbl[0] = '{1, 0,   0, 0,   32640, 896, 1023};
    tbl[1] = '{0, 0,   0, 255, 65280, 768, 1023};
    tbl[2] = '{1, 0,   1, 0,   0,     0,   0};
    tbl[3] = '{1, 0,   2, 0,   32768, 0,   1023};
    tbl[4] = '{0, 10,  0, 13,  768,   768, 768};

    idle(); wr_sel = 0; wr_addr = 0; wr_data = 0;
    rst = 0;
    step(); step();
    check("rst_i_lt", int'(i_lt_256), 1);
    check("rst_sad", int'(sad), 0);
    check("rst_valid", int'(sad_valid), 0);
    @(negedge clk); rst = 1;
    step();
    check("post_rst_i_lt", int'(i_lt_256), 1);

    for (int r = 0; r < 5; r++) begin
      load(0, tbl[r].a_kind, tbl[r].a_c);
      load(1, tbl[r].b_kind, tbl[r].b_c);
      i_clr = 1; sum_clr = 1; step(); idle();
      check($sformatf("r%0d_valid_clr", r), int'(sad_valid), 0);
      for (int c = 0; c < 256; c++) begin
        AB_rd = 1; sum_ld = 1; i_inc = 1;
        step();
        if (c == 254) check($sformatf("r%0d_i_lt_255", r), int'(i_lt_256), 1);
        if (c == 255) check($sformatf("r%0d_i_lt_256", r), int'(i_lt_256), 0);
      end
      idle(); sad_reg_ld = 1; step(); idle();
      check($sformatf("r%0d_sad16", r), int'(sad), tbl[r].exp16);
      check($sformatf("r%0d_valid", r), int'(sad_valid), 1);
`ifdef SAD_SATURATE_EN
      exp10 = tbl[r].exp10_sat;
`else
      exp10 = tbl[r].exp10_wrap;
`endif
      check($sformatf("r%0d_sad10", r), int'(sad_10), exp10);
    end

    // Mid-run reset: reach i=37, sum=500 (indices 0..30 plus 35 with A=k, B=0).
    load(0, 1, 0);
    load(1, 0, 0);
    i_clr = 1; sum_clr = 1; step(); idle();
    for (int k = 0; k < 37; k++) begin
      AB_rd = 1; i_inc = 1; sum_ld = (k <= 30 || k == 35);
      step();
    end
    idle(); sad_reg_ld = 1; step(); idle();
    check("pre_rst_i", int'(dut.i_q), 37);
    check("pre_rst_sum", int'(dut.sum_q), 500);
    check("pre_rst_sad", int'(sad), 500);
    #2 rst = 0;
    #1;
    check("async_rst_i", int'(dut.i_q), 0);
    check("async_rst_sum", int'(dut.sum_q), 0);
    check("async_rst_valid", int'(sad_valid), 0);
    check("async_rst_sad", int'(sad), 0);
    check("async_rst_i_lt", int'(i_lt_256), 1);
    @(negedge clk); rst = 1;

    // Index saturation and i_clr priority.
    i_clr = 1; step(); idle();
    for (int k = 0; k < 300; k++) begin
      i_inc = 1; step();
    end
    idle();
    check("i_hold", int'(dut.i_q), 256);
    check("i_hold_lt", int'(i_lt_256), 0);
    i_clr = 1; i_inc = 1; step(); idle();
    check("i_clr_prio", int'(dut.i_q), 0);
    check("i_clr_prio_lt", int'(i_lt_256), 1);

    // Write to the address being read: old data this cycle, new data next cycle.
    sum_clr = 1; step(); idle();
    for (int k = 0; k < 10; k++) begin
      i_inc = 1; step();
    end
    idle();
    AB_rd = 1; sum_ld = 1; wr_en = 1; wr_sel = 0; wr_addr = 8'd10; wr_data = 8'd200;
    step(); idle();
    check("wr_old_data", int'(dut.sum_q), 10);
    AB_rd = 1; sum_ld = 1; sad_reg_ld = 1;
    step(); idle();
    check("sad_pre_update", int'(sad), 10);
    check("wr_new_data", int'(dut.sum_q), 210);
    sad_reg_ld = 1; step(); idle();
    check("sad_final", int'(sad), 210);
    sum_clr = 1; step(); idle();
    check("valid_cleared", int'(sad_valid), 0);
    check("sad_kept", int'(sad), 210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
